// File: rtl/lcd_write_engine.sv
// Timed 4-bit LCD transmit stage: sends one command/data byte (or a single high nibble)
// with setup, enable pulse, hold, inter-nibble gap and post-command execution wait.
module lcd_write_engine #(
  parameter int unsigned SETUP_CYCLES     = 2,
  parameter int unsigned PULSE_CYCLES     = 12,
  parameter int unsigned HOLD_CYCLES      = 1,
  parameter int unsigned GAP_CYCLES       = 50,
  parameter int unsigned BYTE_WAIT_CYCLES = 2000,
  parameter int unsigned LONG_WAIT_CYCLES = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iNibbleOnly,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HI_SETUP = 4'd1,
    S_HI_PULSE = 4'd2,
    S_HI_HOLD  = 4'd3,
    S_GAP      = 4'd4,
    S_LO_SETUP = 4'd5,
    S_LO_PULSE = 4'd6,
    S_LO_HOLD  = 4'd7,
    S_WAIT     = 4'd8
  } state_t;

  // A zero-length phase still occupies one cycle.
  function automatic logic [31:0] eff(input int unsigned v);
    return (v == 0) ? 32'd1 : v;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_q, nib_d;
  logic        done_q, done_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_data_q, lcd_data_d;
  logic [31:0] limit;
  logic        last;
  logic        long_cmd;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = !rs_q && !nib_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  always_comb begin
    limit = 32'd1;
    case (state_q)
      S_HI_SETUP, S_LO_SETUP: limit = eff(SETUP_CYCLES);
      S_HI_PULSE, S_LO_PULSE: limit = eff(PULSE_CYCLES);
      S_HI_HOLD,  S_LO_HOLD:  limit = eff(HOLD_CYCLES);
      S_GAP:                  limit = eff(GAP_CYCLES);
      S_WAIT:                 limit = long_cmd ? eff(LONG_WAIT_CYCLES) : eff(BYTE_WAIT_CYCLES);
      default:                limit = 32'd1;
    endcase
  end

  assign last = (cnt_q >= limit - 32'd1);

  // Handshake: a request transfers on a clock edge where iValid && oReady; oReady is high
  // only in IDLE, so iValid while busy is ignored and nothing is queued.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          byte_d  = iData;
          rs_d    = iRegisterSelect;
          nib_d   = iNibbleOnly;
          state_d = S_HI_SETUP;
        end
      end
      S_HI_SETUP: if (last) state_d = S_HI_PULSE;
      S_HI_PULSE: if (last) state_d = S_HI_HOLD;
      S_HI_HOLD:  if (last) state_d = nib_q ? S_WAIT : S_GAP;
      S_GAP:      if (last) state_d = S_LO_SETUP;
      S_LO_SETUP: if (last) state_d = S_LO_PULSE;
      S_LO_PULSE: if (last) state_d = S_LO_HOLD;
      S_LO_HOLD:  if (last) state_d = S_WAIT;
      S_WAIT: begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 32'd0;
    else if (state_q != S_IDLE) cnt_d = cnt_q + 32'd1;
    else cnt_d = 32'd0;

    // Pins are registered from the next state so they change cleanly with the state.
    lcd_e_d    = (state_d == S_HI_PULSE) || (state_d == S_LO_PULSE);
    lcd_data_d = 4'd0;
    lcd_rs_d   = 1'b0;
    case (state_d)
      S_HI_SETUP, S_HI_PULSE, S_HI_HOLD, S_GAP: begin
        lcd_data_d = byte_d[7:4];
        lcd_rs_d   = rs_d;
      end
      S_LO_SETUP, S_LO_PULSE, S_LO_HOLD: begin
        lcd_data_d = byte_d[3:0];
        lcd_rs_d   = rs_d;
      end
      default: begin
        lcd_data_d = 4'd0;
        lcd_rs_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      byte_q     <= 8'd0;
      rs_q       <= 1'b0;
      nib_q      <= 1'b0;
      done_q     <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      nib_q      <= nib_d;
      done_q     <= done_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign oReady                  = (state_q == S_IDLE);
  assign oDone                   = done_q;
  assign oLCD_Enabled            = lcd_e_q;
  assign oLCD_RegisterSelect     = lcd_rs_q;
  assign oLCD_Data               = lcd_data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: table of transfers checked cycle by cycle against a timing
// model, hand-written back-to-back / reset sequences, and a zero-parameter instance.
module tb_lcd_write_engine;

  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int HOLD  = 1;
  localparam int GAP   = 50;
  localparam int BWAIT = 300;
  localparam int LWAIT = 1200;

  logic       clk, rst;
  logic       valid, rs, nib;
  logic [7:0] data;
  logic       ready, done, e, rs_o, rw_o, sf_o;
  logic [3:0] d_o, dbg;

  logic       z_valid, z_rs, z_nib;
  logic [7:0] z_data;
  logic       z_ready, z_done, z_e, z_rs_o, z_rw_o, z_sf_o;
  logic [3:0] z_d_o, z_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic       r;
    logic       nb;
    int         n;
  } vec_t;
  vec_t vecs[10];

  lcd_write_engine #(
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .BYTE_WAIT_CYCLES(BWAIT), .LONG_WAIT_CYCLES(LWAIT)
  ) dut (
    .Clock(clk), .Reset(rst), .iValid(valid), .iData(data),
    .iRegisterSelect(rs), .iNibbleOnly(nib), .oReady(ready), .oDone(done),
    .oLCD_Enabled(e), .oLCD_RegisterSelect(rs_o), .oLCD_ReadWrite(rw_o),
    .oLCD_StrataFlashControl(sf_o), .oLCD_Data(d_o), .dbg_state(dbg)
  );

  lcd_write_engine #(
    .SETUP_CYCLES(0), .PULSE_CYCLES(1), .HOLD_CYCLES(0),
    .GAP_CYCLES(0), .BYTE_WAIT_CYCLES(0), .LONG_WAIT_CYCLES(3)
  ) dut_z (
    .Clock(clk), .Reset(rst), .iValid(z_valid), .iData(z_data),
    .iRegisterSelect(z_rs), .iNibbleOnly(z_nib), .oReady(z_ready), .oDone(z_done),
    .oLCD_Enabled(z_e), .oLCD_RegisterSelect(z_rs_o), .oLCD_ReadWrite(z_rw_o),
    .oLCD_StrataFlashControl(z_sf_o), .oLCD_Data(z_d_o), .dbg_state(z_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected {ready, done, e, rs, data} in cycle c after acceptance, n busy cycles.
  function automatic logic [7:0] model(input int c, input int n, input logic [7:0] b,
                                       input logic r, input logic nb);
    int hi_end, lo0;
    logic [3:0] hi, lo;
    hi = b[7:4];
    lo = b[3:0];
    hi_end = SETUP + PULSE + HOLD;
    lo0 = hi_end + GAP;
    if (c == n + 1) return 8'b1100_0000;
    if (c <= SETUP) return {3'b000, r, hi};
    if (c <= SETUP + PULSE) return {3'b001, r, hi};
    if (c <= hi_end) return {3'b000, r, hi};
    if (nb) return 8'h00;
    if (c <= lo0) return {3'b000, r, hi};
    if (c <= lo0 + SETUP) return {3'b000, r, lo};
    if (c <= lo0 + SETUP + PULSE) return {3'b001, r, lo};
    if (c <= lo0 + SETUP + PULSE + HOLD) return {3'b000, r, lo};
    return 8'h00;
  endfunction

  // Driver + per-cycle monitor for one transfer; inputs are scrambled while busy.
  task automatic run_transfer(input string name, input logic [7:0] b, input logic r,
                              input logic nb, input int n);
    int bad, first_bad;
    logic [7:0] exp_v, obs_v, first_obs, first_exp;
    bit seen;
    bad = 0; first_bad = -1; seen = 0; first_obs = 8'h0; first_exp = 8'h0;
    @(negedge clk);
    check({name, " ready at request"}, ready, 1);
    valid = 1'b1; data = b; rs = r; nib = nb;
    exp_q.push_back(n + 1);
    for (int c = 1; c <= n + 21 && !seen; c++) begin
      @(negedge clk);
      if (c <= n + 1) begin
        exp_v = model(c, n, b, r, nb);
        obs_v = {ready, done, e, rs_o, d_o};
        if (obs_v !== exp_v) begin
          bad++;
          if (first_bad < 0) begin
            first_bad = c; first_obs = obs_v; first_exp = exp_v;
          end
        end
      end
      if (done) begin
        seen = 1;
        check({name, " done cycle"}, c, exp_q.pop_front());
      end
      if (c <= n) begin
        valid = 1'($urandom_range(0, 1));
        data  = 8'($urandom_range(0, 255));
        rs    = 1'($urandom_range(0, 1));
        nib   = 1'($urandom_range(0, 1));
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    if (!seen) begin
      checks++; failures++;
      void'(exp_q.pop_front());
      $display("FAIL %s done timeout: no oDone within %0d cycles, required at %0d", name, n + 21, n + 1);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s pins: %0d bad cycles, first at %0d got {rdy,done,e,rs,d}=0x%0h expected 0x%0h",
               name, bad, first_bad, first_obs, first_exp);
    end
  endtask

  task automatic z_run(input string name, input logic [7:0] b, input logic r,
                       input logic nb, input int n);
    int e_cnt;
    bit seen;
    e_cnt = 0; seen = 0;
    @(negedge clk);
    z_valid = 1'b1; z_data = b; z_rs = r; z_nib = nb;
    for (int c = 1; c <= n + 20 && !seen; c++) begin
      @(negedge clk);
      z_valid = 1'b0;
      if (z_e) e_cnt++;
      if (z_done) begin
        seen = 1;
        check({name, " done cycle"}, c, n + 1);
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s done timeout: no oDone, required at %0d", name, n + 1);
    end
    check({name, " e pulses"}, e_cnt, nb ? 1 : 2);
    check({name, " idle pins"}, {z_ready, z_rs_o, z_d_o, z_dbg, z_rw_o, z_sf_o}, {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1});
  endtask

  initial begin
    int bad, dcount, first_done;
    rst = 1'b1; valid = 1'b0; data = 8'h0; rs = 1'b0; nib = 1'b0;
    z_valid = 1'b0; z_data = 8'h0; z_rs = 1'b0; z_nib = 1'b0;

    vecs[0] = '{8'h48, 1'b1, 1'b0, 380};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 1280};
    vecs[2] = '{8'h30, 1'b0, 1'b1, 315};
    vecs[3] = '{8'h02, 1'b0, 1'b0, 1280};
    vecs[4] = '{8'h03, 1'b0, 1'b0, 1280};
    vecs[5] = '{8'h04, 1'b0, 1'b0, 380};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 380};
    vecs[7] = '{8'h01, 1'b0, 1'b1, 315};
    vecs[8] = '{8'($urandom_range(0, 255)), 1'b1, 1'b0, 380};
    vecs[9] = '{8'($urandom_range(0, 255)), 1'b0, 1'b1, 315};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset state", {ready, done, e, rs_o, d_o, dbg}, {8'h80, 4'h0});
    check("constant pins", {rw_o, sf_o}, 2'b01);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({ready, done, e, d_o} !== 7'b1000000) bad++;
    end
    check("idle 100 cycles bad count", bad, 0);

    for (int i = 0; i < 10; i++)
      run_transfer($sformatf("vec%0d(0x%0h)", i, vecs[i].b), vecs[i].b, vecs[i].r, vecs[i].nb, vecs[i].n);

    // Back-to-back: valid held; 0x42 offered in the oDone cycle.
    @(negedge clk);
    valid = 1'b1; data = 8'h41; rs = 1'b1; nib = 1'b0;
    exp_q.push_back(381);
    exp_q.push_back(762);
    dcount = 0; first_done = -1;
    for (int c = 1; c <= 820; c++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (exp_q.size() > 0) check($sformatf("b2b done #%0d cycle", dcount), c, exp_q.pop_front());
        if (first_done < 0) begin
          first_done = c;
          data = 8'h42;
        end
      end
      if (first_done > 0 && c == first_done + 1) begin
        check("b2b second accepted busy", ready, 0);
        check("b2b second hi nibble", d_o, 4'h4);
        valid = 1'b0;
      end
      if (first_done > 0 && c == first_done + 66) check("b2b second lo nibble", d_o, 4'h2);
    end
    valid = 1'b0;
    check("b2b transfer count", dcount, 2);
    exp_q.delete();

    // Reset while E is high.
    @(negedge clk);
    valid = 1'b1; data = 8'h48; rs = 1'b1; nib = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    check("e high before reset", e, 1);
    rst = 1'b1;
    @(negedge clk);
    check("after mid reset pins", {ready, done, e, rs_o, d_o, dbg}, {8'h80, 4'h0});
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("no done after dropped transfer", dcount, 0);
    run_transfer("after reset 0xC3", 8'hC3, 1'b0, 1'b0, 380);

    // Reset and valid together: nothing captured.
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; data = 8'h01; rs = 1'b0;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ready !== 1'b1 || e !== 1'b0) bad++;
    end
    check("reset beats valid", bad, 0);

    // Zero-valued parameters behave as one cycle.
    z_run("zero byte 0x55", 8'h55, 1'b1, 1'b0, 8);
    z_run("zero long 0x02", 8'h02, 1'b0, 1'b0, 10);
    z_run("zero nibble 0x30", 8'h30, 1'b0, 1'b1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Timed 4-bit transmit stage for the character LCD.
- Upstream controllers (power-on init sequencer, text/cursor sequencer) hand it one command or data byte per valid/ready handshake.
- It produces the LCD pin waveforms: high nibble then low nibble, with setup, enable pulse, hold, inter-nibble gap and post-command execution wait.
- A nibble-only mode issues the single-nibble writes of the power-on sequence (0x3, 0x3, 0x3, 0x2).

Parameters:
- SETUP_CYCLES, 2: cycles data/RS are stable before E rises.
- PULSE_CYCLES, 12: cycles E is high.
- HOLD_CYCLES, 1: cycles data/RS are held after E falls.
- GAP_CYCLES, 50: cycles between end of high-nibble hold and start of low-nibble setup.
- BYTE_WAIT_CYCLES, 2000: execution wait after a normal write.
- LONG_WAIT_CYCLES, 82000: execution wait after clear/home commands.

Ports:
- Clock  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high
- iValid  input  1  request present
- iData  input  8  byte to send; nibble-only mode uses iData[7:4]
- iRegisterSelect  input  1  0 = command, 1 = data
- iNibbleOnly  input  1  1 = send high nibble only
- oReady  output  1  engine idle, request will be accepted
- oDone  output  1  one-cycle pulse, transfer including wait complete
- oLCD_Enabled  output  1  LCD E
- oLCD_RegisterSelect  output  1  LCD RS
- oLCD_ReadWrite  output  1  constant 0
- oLCD_StrataFlashControl  output  1  constant 1
- oLCD_Data  output  4  LCD DB[7:4]

Behaviour:
- One clock (Clock); Reset is synchronous, active-high. On a Reset edge: state IDLE, counter 0, oLCD_Enabled=0, oLCD_Data=0, oLCD_RegisterSelect=0, oDone=0. oReady=1 from the first IDLE cycle.
- States: IDLE, HI_SETUP, HI_PULSE, HI_HOLD, GAP, LO_SETUP, LO_PULSE, LO_HOLD, WAIT.
- Each timed state lasts exactly its parameter count in cycles. The counter resets on every state change. A parameter value of 0 behaves as 1.
- Acceptance: iValid && oReady sampled at an edge in IDLE. At that edge the engine captures iData, iRegisterSelect and iNibbleOnly, then enters HI_SETUP.
  - iValid while not in IDLE is ignored; nothing is queued.
  - Input changes after acceptance do not affect outputs.
- Output levels by state:
  - HI_SETUP, HI_PULSE, HI_HOLD, GAP: oLCD_Data = captured[7:4].
  - LO_SETUP, LO_PULSE, LO_HOLD: oLCD_Data = captured[3:0].
  - WAIT and IDLE: oLCD_Data = 0 and oLCD_RegisterSelect = 0.
  - oLCD_RegisterSelect = captured RS in all non-IDLE states except WAIT.
  - oLCD_Enabled = 1 only in HI_PULSE and LO_PULSE.
  - All pin outputs are registered or decoded glitch-free from state.
- Sequence:
  - HI_SETUP → HI_PULSE → HI_HOLD.
  - From HI_HOLD: nibble-only → WAIT; otherwise → GAP → LO_SETUP → LO_PULSE → LO_HOLD → WAIT.
- Wait length: LONG_WAIT_CYCLES when captured RS=0, nibble-only=0 and byte ∈ {0x01, 0x02, 0x03}. Otherwise BYTE_WAIT_CYCLES.
- Exiting WAIT → IDLE. In that first IDLE cycle oDone=1 for exactly one cycle and oReady=1. A new request accepted in that same cycle is legal (back-to-back, no bubble).
- Latency: acceptance in cycle 0 ⇒ busy cycles 1..N, oDone in cycle N+1.
  - Full byte, defaults: N = 2+12+1+50+2+12+1+2000 = 2080.
  - Long command: N = 82080.
  - Nibble-only: N = 15+2000 = 2015.
- Counter is 32 bits; no wrap is possible for legal parameters.
- Reset mid-transfer, including while E is high: next cycle is IDLE with E=0 and pins 0. No oDone is produced and the transfer is dropped.
- Reset and iValid in the same cycle: Reset wins and nothing is captured.

Test Plan:
- Reset released, iValid=0 for 100 cycles → oReady=1, E=0, oLCD_Data=0, oDone never pulses.
- Accept iData=0x48, RS=1 at cycle 0 → RS=1 in cycles 1–80; data=0x4 in 1–65 and 0x8 in 66–80; E=1 exactly in 3–14 and 68–79; WAIT 81–2080; oDone only at 2081.
- Accept command 0x01, RS=0 → E pulses at 3–14 and 68–79; oDone at cycle 82081; oReady=0 from cycle 1 to 82080.
- Nibble-only iData=0x30, RS=0 → single E pulse at 3–14 with data=0x3; oDone at cycle 2016; no low-nibble pulse.
- Hold iValid=1 continuously with 0x41, then 0x42 presented on the cycle oDone pulses → 0x42 accepted in the oDone cycle; a second 0x41 presented mid-transfer is not captured; exactly two transfers occur.
- Assert Reset for 1 cycle at cycle 8 of a byte write (E high) → E=0 and pins 0 at cycle 9; oReady=1; no oDone; a fresh request then completes normally.
